// File: rtl/uart_param_pkg.sv
// rtl/uart_param_pkg.sv - shared UART FSM states, frame-format encodings and oversample limits
package uart_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  typedef enum logic [1:0] {
    DBITS_5 = 2'd0,
    DBITS_6 = 2'd1,
    DBITS_7 = 2'd2,
    DBITS_8 = 2'd3
  } data_bits_e;

  localparam int OVS_MIN = 8;
  localparam int OVS_MAX = 16;

  // Forces the oversample ratio into the supported even range.
  function automatic int ovs_legal(input int ovs);
    if (ovs < OVS_MIN) return OVS_MIN;
    if (ovs > OVS_MAX) return OVS_MAX;
    return (ovs / 2) * 2;
  endfunction

  function automatic logic [3:0] frame_bits(input logic [1:0] enc);
    return 4'd5 + {2'b00, enc};
  endfunction

  function automatic logic [7:0] frame_mask(input logic [1:0] enc);
    return 8'hFF >> (2'd3 - enc);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with zero-latency head output and occupancy count
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full, empty, do_wr, do_rd;

  // A read paired with a write is honoured even at the empty/full boundaries.
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LW'(DEPTH));
    do_wr    = wr_en && (!full || rd_en);
    do_rd    = rd_en && (!empty || wr_en);
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (do_wr && !do_rd) begin
      level_d = level_q + 1'b1;
    end else if (do_rd && !do_wr) begin
      level_d = level_q - 1'b1;
    end
    rd_data = empty ? '0 : mem[rd_ptr_q];
    level   = level_q;
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_param_core.sv
// rtl/uart_param_core.sv - UART with TX/RX FIFOs, runtime frame format and shared baud tick
module uart_param_core
  import uart_param_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [BAUD_W-1:0]             BAUD_DIV,
  input  logic [1:0]                    DATA_BITS,
  input  logic                          PARITY_EN,
  input  logic                          ODD_N_EVEN,
  input  logic                          STOP2,
  input  logic [7:0]                    TX_DATA,
  input  logic                          TX_WR,
  output logic                          TX_FULL,
  output logic                          TX_EMPTY,
  output logic                          TX,
  input  logic                          RX,
  output logic [7:0]                    RX_DATA,
  output logic                          RX_PERR,
  output logic                          RX_FERR,
  input  logic                          RX_RD,
  output logic                          RX_EMPTY,
  output logic                          OVERFLOW,
  input  logic                          OVF_CLR,
  output logic [$clog2(FIFO_DEPTH):0]   RX_LEVEL
);

  localparam int              LW      = $clog2(FIFO_DEPTH) + 1;
  localparam int              OVS     = ovs_legal(OVERSAMPLE);
  localparam logic [4:0]      OS_LAST = 5'(OVS - 1);
  localparam logic [4:0]      OS_MID  = 5'(OVS / 2 - 1);

  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic              tick;

  always_comb begin
    tick       = (baud_cnt_q >= BAUD_DIV);
    baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
  end

  // ---------------- transmitter ----------------
  logic [7:0]    tx_head;
  logic [LW-1:0] tx_level;
  logic          tx_push, tx_pop, tx_load, tx_bit_end, tx_fifo_empty;

  uart_state_e tx_state_q, tx_state_d;
  logic [4:0]  tx_os_q, tx_os_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  tx_nbits_q, tx_nbits_d;
  logic        tx_par_en_q, tx_par_en_d;
  logic        tx_par_q, tx_par_d;
  logic        tx_stop2_q, tx_stop2_d;
  logic        tx_stop_idx_q, tx_stop_idx_d;

  assign tx_fifo_empty = (tx_level == '0);
  assign TX_FULL       = (tx_level == LW'(FIFO_DEPTH));
  assign tx_push       = TX_WR && !TX_FULL;
  assign TX_EMPTY      = tx_fifo_empty && (tx_state_q == ST_IDLE);

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (CLK),
    .reset   (RESET),
    .wr_en   (tx_push),
    .wr_data (TX_DATA),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .level   (tx_level)
  );

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_os_d       = tx_os_q;
    tx_bit_d      = tx_bit_q;
    tx_shift_d    = tx_shift_q;
    tx_nbits_d    = tx_nbits_q;
    tx_par_en_d   = tx_par_en_q;
    tx_par_d      = tx_par_q;
    tx_stop2_d    = tx_stop2_q;
    tx_stop_idx_d = tx_stop_idx_q;
    tx_pop        = 1'b0;
    tx_load       = 1'b0;
    tx_bit_end    = tick && (tx_os_q == OS_LAST);
    if (tx_state_q != ST_IDLE && tick) begin
      tx_os_d = tx_bit_end ? '0 : tx_os_q + 5'd1;
    end
    case (tx_state_q)
      ST_IDLE:   tx_load = !tx_fifo_empty;
      ST_START:  if (tx_bit_end) tx_state_d = ST_DATA;
      ST_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if ({1'b0, tx_bit_q} == tx_nbits_q - 4'd1) begin
            tx_state_d = tx_par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: if (tx_bit_end) tx_state_d = ST_STOP;
      ST_STOP: begin
        if (tx_bit_end) begin
          if (tx_stop2_q && !tx_stop_idx_q) begin
            tx_stop_idx_d = 1'b1;
          end else if (!tx_fifo_empty) begin
            tx_load = 1'b1;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end
      end
      default:   tx_state_d = ST_IDLE;
    endcase
    // Frame format is captured at pop so later config writes cannot disturb it.
    if (tx_load) begin
      tx_pop        = 1'b1;
      tx_state_d    = ST_START;
      tx_os_d       = '0;
      tx_bit_d      = '0;
      tx_stop_idx_d = 1'b0;
      tx_nbits_d    = frame_bits(DATA_BITS);
      tx_shift_d    = tx_head & frame_mask(DATA_BITS);
      tx_par_d      = (^(tx_head & frame_mask(DATA_BITS))) ^ ODD_N_EVEN;
      tx_par_en_d   = PARITY_EN;
      tx_stop2_d    = STOP2;
    end
  end

  always_comb begin
    case (tx_state_q)
      ST_START:  TX = 1'b0;
      ST_DATA:   TX = tx_shift_q[0];
      ST_PARITY: TX = tx_par_q;
      default:   TX = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic [9:0]    rx_head, rx_entry;
  logic [LW-1:0] rx_level;
  logic          rx_push, rx_sample, rx_fall, rx_full;

  uart_state_e rx_state_q, rx_state_d;
  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [4:0]  rx_os_q, rx_os_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [3:0]  rx_nbits_q, rx_nbits_d;
  logic        rx_par_en_q, rx_par_en_d;
  logic        rx_odd_q, rx_odd_d;
  logic        rx_perr_q, rx_perr_d;
  logic        ovf_q, ovf_d;

  assign rx_full  = (rx_level == LW'(FIFO_DEPTH));
  assign rx_fall  = rx_prev_q && !rx_s2_q;
  assign rx_entry = {~rx_s2_q, rx_perr_q, rx_data_q};
  assign RX_DATA  = rx_head[7:0];
  assign RX_PERR  = rx_head[8];
  assign RX_FERR  = rx_head[9];
  assign RX_EMPTY = (rx_level == '0);
  assign RX_LEVEL = rx_level;
  assign OVERFLOW = ovf_q;

  uart_sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (CLK),
    .reset   (RESET),
    .wr_en   (rx_push),
    .wr_data (rx_entry),
    .rd_en   (RX_RD),
    .rd_data (rx_head),
    .level   (rx_level)
  );

  always_comb begin
    rx_s1_d     = RX;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    rx_state_d  = rx_state_q;
    rx_os_d     = rx_os_q;
    rx_bit_d    = rx_bit_q;
    rx_data_d   = rx_data_q;
    rx_nbits_d  = rx_nbits_q;
    rx_par_en_d = rx_par_en_q;
    rx_odd_d    = rx_odd_q;
    rx_perr_d   = rx_perr_q;
    rx_push     = 1'b0;
    // First sample lands half a bit in; every later one a full bit after it.
    rx_sample   = tick && (rx_os_q == ((rx_state_q == ST_START) ? OS_MID : OS_LAST));
    if (rx_state_q != ST_IDLE && tick) begin
      rx_os_d = rx_sample ? '0 : rx_os_q + 5'd1;
    end
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_d  = ST_START;
          rx_os_d     = '0;
          rx_bit_d    = '0;
          rx_data_d   = '0;
          rx_perr_d   = 1'b0;
          rx_nbits_d  = frame_bits(DATA_BITS);
          rx_par_en_d = PARITY_EN;
          rx_odd_d    = ODD_N_EVEN;
        end
      end
      ST_START:  if (rx_sample) rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (rx_sample) begin
          rx_data_d[rx_bit_q] = rx_s2_q;
          rx_bit_d            = rx_bit_q + 3'd1;
          if ({1'b0, rx_bit_q} == rx_nbits_q - 4'd1) begin
            rx_state_d = rx_par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (rx_sample) begin
          rx_perr_d  = rx_s2_q != ((^rx_data_q) ^ rx_odd_q);
          rx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (rx_sample) begin
          rx_push    = 1'b1;
          rx_state_d = ST_IDLE;
        end
      end
      default:   rx_state_d = ST_IDLE;
    endcase
    ovf_d = ovf_q;
    if (OVF_CLR) ovf_d = 1'b0;
    if (rx_push && rx_full && !RX_RD) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      baud_cnt_q    <= '0;
      tx_state_q    <= ST_IDLE;
      tx_os_q       <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_nbits_q    <= 4'd8;
      tx_par_en_q   <= 1'b0;
      tx_par_q      <= 1'b0;
      tx_stop2_q    <= 1'b0;
      tx_stop_idx_q <= 1'b0;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= ST_IDLE;
      rx_os_q       <= '0;
      rx_bit_q      <= '0;
      rx_data_q     <= '0;
      rx_nbits_q    <= 4'd8;
      rx_par_en_q   <= 1'b0;
      rx_odd_q      <= 1'b0;
      rx_perr_q     <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      baud_cnt_q    <= baud_cnt_d;
      tx_state_q    <= tx_state_d;
      tx_os_q       <= tx_os_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      tx_nbits_q    <= tx_nbits_d;
      tx_par_en_q   <= tx_par_en_d;
      tx_par_q      <= tx_par_d;
      tx_stop2_q    <= tx_stop2_d;
      tx_stop_idx_q <= tx_stop_idx_d;
      rx_s1_q       <= rx_s1_d;
      rx_s2_q       <= rx_s2_d;
      rx_prev_q     <= rx_prev_d;
      rx_state_q    <= rx_state_d;
      rx_os_q       <= rx_os_d;
      rx_bit_q      <= rx_bit_d;
      rx_data_q     <= rx_data_d;
      rx_nbits_q    <= rx_nbits_d;
      rx_par_en_q   <= rx_par_en_d;
      rx_odd_q      <= rx_odd_d;
      rx_perr_q     <= rx_perr_d;
      ovf_q         <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_param_core.sv
// tb/tb_uart_param_core.sv - directed self-checking bench for uart_param_core
module tb_uart_param_core;

  localparam int FIFO_DEPTH = 4;
  localparam int BAUD_W     = 16;
  localparam int OVERSAMPLE = 16;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [BAUD_W-1:0] baud_div;
  logic [1:0]        data_bits;
  logic              parity_en, odd_n_even, stop2;
  logic [7:0]        tx_data;
  logic              tx_wr, tx_full, tx_empty, tx;
  logic              rx_drv, loop_en, rx_line;
  logic [7:0]        rx_data;
  logic              rx_perr, rx_ferr, rx_rd, rx_empty, overflow, ovf_clr;
  logic [LW-1:0]     rx_level;

  int checks = 0;
  int errors = 0;
  int cnt;
  logic [7:0] ovf_bytes [5];

  assign rx_line = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_param_core #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_W     (BAUD_W),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .CLK        (clk),
    .RESET      (reset),
    .BAUD_DIV   (baud_div),
    .DATA_BITS  (data_bits),
    .PARITY_EN  (parity_en),
    .ODD_N_EVEN (odd_n_even),
    .STOP2      (stop2),
    .TX_DATA    (tx_data),
    .TX_WR      (tx_wr),
    .TX_FULL    (tx_full),
    .TX_EMPTY   (tx_empty),
    .TX         (tx),
    .RX         (rx_line),
    .RX_DATA    (rx_data),
    .RX_PERR    (rx_perr),
    .RX_FERR    (rx_ferr),
    .RX_RD      (rx_rd),
    .RX_EMPTY   (rx_empty),
    .OVERFLOW   (overflow),
    .OVF_CLR    (ovf_clr),
    .RX_LEVEL   (rx_level)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic write_tx(input logic [7:0] b);
    tx_data = b;
    tx_wr   = 1'b1;
    step();
    tx_wr   = 1'b0;
  endtask

  task automatic pop_rx();
    rx_rd = 1'b1;
    step();
    rx_rd = 1'b0;
  endtask

  // 8N1 at BAUD_DIV=0: start bit visible one cycle after the write, each bit 16 cycles.
  task automatic tx_frame_check(input string tag, input logic [7:0] b);
    logic [9:0] bits;
    int bad;
    bits = {1'b1, b, 1'b0};
    write_tx(b);
    chk($sformatf("%s_idle_before_start", tag), 32'(tx), 32'd1);
    step();
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int k = 0; k < 16; k++) begin
        if (tx !== bits[i]) bad++;
        step();
      end
      chk($sformatf("%s_bit%0d_wrong_cycles", tag, i), 32'(bad), 32'd0);
    end
    chk($sformatf("%s_tx_empty_after", tag), 32'(tx_empty), 32'd1);
  endtask

  task automatic send_rx_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      step(16);
    end
    rx_drv = 1'b1;
    step(16);
  endtask

  initial begin
    ovf_bytes[0] = 8'h11; ovf_bytes[1] = 8'h22; ovf_bytes[2] = 8'h33;
    ovf_bytes[3] = 8'h44; ovf_bytes[4] = 8'h55;
    reset = 1'b1; baud_div = '0; data_bits = 2'd3; parity_en = 1'b0;
    odd_n_even = 1'b0; stop2 = 1'b0; tx_data = '0; tx_wr = 1'b0;
    rx_drv = 1'b1; loop_en = 1'b0; rx_rd = 1'b0; ovf_clr = 1'b0;
    step(3);

    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_empty", 32'(tx_empty), 32'd1);
    chk("rst_tx_full", 32'(tx_full), 32'd0);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    chk("rst_rx_level", 32'(rx_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_perr", 32'(rx_perr), 32'd0);
    chk("rst_rx_ferr", 32'(rx_ferr), 32'd0);
    reset = 1'b0;
    step(2);

    tx_frame_check("a5", 8'hA5);

    // Six back-to-back writes into a 4-deep FIFO: the sixth is dropped, so five frames.
    for (int i = 0; i < 6; i++) write_tx(8'(8'h60 + i));
    chk("txfull_after_burst", 32'(tx_full), 32'd1);
    cnt = 0;
    while (!tx_empty && cnt < 2000) begin
      step();
      cnt++;
    end
    chk("txburst_cycles_to_empty", 32'(cnt), 32'd796);

    // BAUD_DIV=2 -> every full bit is 48 cycles; data bit0 of 0x01 is the only high run.
    baud_div = 16'd2;
    write_tx(8'h01);
    cnt = 0;
    while (tx !== 1'b0 && cnt < 20) begin step(); cnt++; end
    chk("baud_start_seen", 32'(tx), 32'd0);
    cnt = 0;
    while (tx === 1'b0 && cnt < 200) begin step(); cnt++; end
    cnt = 0;
    while (tx === 1'b1 && cnt < 200) begin step(); cnt++; end
    chk("baud_bit_width", 32'(cnt), 32'd48);
    cnt = 0;
    while (!tx_empty && cnt < 1000) begin step(); cnt++; end
    chk("baud_done", 32'(tx_empty), 32'd1);
    baud_div = '0;
    step(4);

    // Loopback 7O2; config flips to 8N1 while the second frame is in flight.
    loop_en = 1'b1; data_bits = 2'd2; parity_en = 1'b1; odd_n_even = 1'b1; stop2 = 1'b1;
    write_tx(8'h3F);
    write_tx(8'h00);
    cnt = 0;
    while (rx_level != 1 && cnt < 400) begin step(); cnt++; end
    chk("loop_first_push", 32'(rx_level), 32'd1);
    step(40);
    data_bits = 2'd3; parity_en = 1'b0; odd_n_even = 1'b0; stop2 = 1'b0;
    cnt = 0;
    while (rx_level != 2 && cnt < 400) begin step(); cnt++; end
    chk("loop_level2", 32'(rx_level), 32'd2);
    chk("loop_b0_data", 32'(rx_data), 32'h3F);
    chk("loop_b0_perr", 32'(rx_perr), 32'd0);
    chk("loop_b0_ferr", 32'(rx_ferr), 32'd0);
    pop_rx();
    chk("loop_b1_data", 32'(rx_data), 32'h00);
    chk("loop_b1_perr", 32'(rx_perr), 32'd0);
    chk("loop_b1_ferr", 32'(rx_ferr), 32'd0);
    pop_rx();
    chk("loop_rx_empty", 32'(rx_empty), 32'd1);
    cnt = 0;
    while (!tx_empty && cnt < 400) begin step(); cnt++; end
    loop_en = 1'b0;
    step(20);

    rx_drv = 1'b0;
    step(5);
    rx_drv = 1'b1;
    step(40);
    chk("glitch_rx_empty", 32'(rx_empty), 32'd1);
    chk("glitch_rx_level", 32'(rx_level), 32'd0);

    // 8E1 0x01 needs parity 1; send parity 0 and a low stop bit.
    parity_en = 1'b1; odd_n_even = 1'b0;
    send_rx_bits({1'b0, 1'b0, 8'h01, 1'b0}, 11);
    chk("err_level", 32'(rx_level), 32'd1);
    chk("err_data", 32'(rx_data), 32'h01);
    chk("err_perr", 32'(rx_perr), 32'd1);
    chk("err_ferr", 32'(rx_ferr), 32'd1);
    pop_rx();
    chk("err_popped", 32'(rx_empty), 32'd1);
    parity_en = 1'b0;

    for (int i = 0; i < 5; i++) send_rx_bits({2'b01, ovf_bytes[i], 1'b0}, 10);
    chk("ovf_level", 32'(rx_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("ovf_level_kept", 32'(rx_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_byte%0d", i), 32'(rx_data), 32'(ovf_bytes[i]));
      pop_rx();
    end
    chk("ovf_drained", 32'(rx_empty), 32'd1);

    // Reset in the middle of data bit 4 of 0xC3 (a 0 bit).
    write_tx(8'hC3);
    step(81);
    chk("rst_mid_frame_bit4", 32'(tx), 32'd0);
    reset = 1'b1;
    step();
    chk("rst_mid_tx_high", 32'(tx), 32'd1);
    chk("rst_mid_tx_empty", 32'(tx_empty), 32'd1);
    reset = 1'b0;
    step();
    tx_frame_check("after_rst", 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
